sle_stream_loader: RTL and testbench

Upstream feeder for a WIDTH-bit bank of SLE registers. It receives a serial bit stream over a valid/ready handshake and assembles it into words. For each completed word it drives the bank's D/EN/SLn/SD/ALn/ADn/LAT inputs with one registered synchronous-load strobe. It also issues a power-up asynchronous initialisation and on-request synchronous clears of the bank.

---
 rtl/sle_ldr_pkg.sv | 27 ++
 rtl/sle_ldr_deser.sv | 88 ++++++++
 rtl/sle_stream_loader.sv | 181 ++++++++++++++++++
 tb/tb_sle_stream_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sle_ldr_pkg.sv
// rtl/sle_ldr_pkg.sv - shared types and helpers for the SLE stream loader
//
// Purpose : loader FSM state encoding and counter-width helper.
// Ports   : none (package).
package sle_ldr_pkg;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_LOAD    = 2'd2,
    ST_CLEAR   = 2'd3
  } sle_state_e;

  // Number of bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Bit-counter width for a WIDTH-bit word (room for a trailing parity bit).
  function automatic int cnt_width(input int width);
    return clog2(width + 1);
  endfunction

endpackage

// File: rtl/sle_ldr_deser.sv
// rtl/sle_ldr_deser.sv - serial-to-parallel frame assembler for the SLE loader
//
// Purpose : shift register, bit counter, parity accumulator and frame-done flag.
// Config  : SLE_LDR_PARITY_EN adds a trailing even-parity bit to each frame.
// Ports   : clk_i, rst_ni   - clock, async active-low reset
//           bit_i           - serial bit (MSB first)
//           accept_i        - bit_i is consumed on this edge
//           clr_i           - discard the partial frame on this edge
//           word_o          - assembled word, valid while frame_done_o
//           frame_done_o    - final bit of the frame is being accepted
//           parity_ok_o     - parity check result, valid while frame_done_o
module sle_ldr_deser
  import sle_ldr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             bit_i,
  input  logic             accept_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] word_o,
  output logic             frame_done_o,
  output logic             parity_ok_o
);

  localparam int CW = cnt_width(WIDTH);

  // The shift register holds every data bit except the one arriving on the
  // final edge; without parity that last bit is the word LSB and is spliced
  // in combinationally so D can be registered on the same edge.
`ifdef SLE_LDR_PARITY_EN
  localparam int FRAME = WIDTH + 1;
  localparam int SW    = WIDTH;
`else
  localparam int FRAME = WIDTH;
  localparam int SW    = WIDTH - 1;
`endif

  logic [SW-1:0] shreg_q, shreg_d;
  logic [CW-1:0] bitcnt_q, bitcnt_d;
  logic          shift_en;

  assign frame_done_o = accept_i && (bitcnt_q == CW'(FRAME - 1));

`ifdef SLE_LDR_PARITY_EN
  logic par_q, par_d;

  // The parity bit itself is not shifted into the word.
  assign shift_en    = accept_i && (bitcnt_q < CW'(WIDTH));
  assign word_o      = shreg_q;
  assign parity_ok_o = (par_q == bit_i);

  always_comb begin
    par_d = par_q;
    if (clr_i || frame_done_o) par_d = 1'b0;
    else if (shift_en)         par_d = par_q ^ bit_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) par_q <= 1'b0;
    else         par_q <= par_d;
  end
`else
  assign shift_en    = accept_i;
  assign word_o      = {shreg_q, bit_i};
  assign parity_ok_o = 1'b1;
`endif

  always_comb begin
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    if (shift_en) shreg_d = SW'({shreg_q, bit_i});
    if (clr_i || frame_done_o) bitcnt_d = '0;
    else if (accept_i)         bitcnt_d = bitcnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
    end
  end

endmodule

// File: rtl/sle_stream_loader.sv
// rtl/sle_stream_loader.sv - serial stream loader driving a bank of SLE registers
//
// Purpose : assembles a serial bit stream into WIDTH-bit words and issues one
//           synchronous-load strobe per word, a power-up async init, and
//           on-request synchronous clears of the bank.
// Config  : SLE_LDR_PARITY_EN - frames carry a trailing even-parity bit;
//           mismatching frames pulse err instead of loading.
// Ports   : CLK, RSTn          - clock, async active-low reset
//           s_data/s_valid/s_ready - serial bit stream handshake
//           clr_req/clr_ack    - clear request level / one-cycle ack
//           D, EN, SLn, SD     - bank sync-load interface
//           ALn, ADn, LAT      - bank async init and latch mode
//           err                - parity failure pulse
//           load_cnt           - completed load count (wraps)
module sle_stream_loader
  import sle_ldr_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int INIT_CYCLES = 2,
  parameter bit INIT_VAL    = 1'b0
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             clr_req,
  output logic             clr_ack,
  output logic [WIDTH-1:0] D,
  output logic             EN,
  output logic             SLn,
  output logic             SD,
  output logic             ALn,
  output logic             ADn,
  output logic             LAT,
  output logic             err,
  output logic [7:0]       load_cnt
);

  localparam int IW = clog2(INIT_CYCLES + 1);

  sle_state_e       state_q, state_d;
  logic [IW-1:0]    init_cnt_q, init_cnt_d;
  logic             ready_q, ready_d;
  logic             en_q, en_d;
  logic             sln_q, sln_d;
  logic             aln_q, aln_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             clr_ack_q, clr_ack_d;
  logic             err_q, err_d;
  logic [7:0]       load_cnt_q, load_cnt_d;
  logic             clr_pend_q, clr_pend_d;

  logic             accept;
  logic             clr_now;
  logic [WIDTH-1:0] word;
  logic             frame_done;
  logic             parity_ok;

  // ready_q is the registered "collecting" state; a clear request withdraws
  // it in the same cycle so a clear-cycle bit is never taken from upstream.
  assign s_ready = ready_q & ~clr_req & ~clr_pend_q;
  assign accept  = s_valid & s_ready;
  assign clr_now = (state_q == ST_COLLECT) & (clr_req | clr_pend_q);

  sle_ldr_deser #(.WIDTH(WIDTH)) u_deser (
    .clk_i        (CLK),
    .rst_ni       (RSTn),
    .bit_i        (s_data),
    .accept_i     (accept),
    .clr_i        (clr_now),
    .word_o       (word),
    .frame_done_o (frame_done),
    .parity_ok_o  (parity_ok)
  );

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ready_d    = 1'b0;
    en_d       = 1'b0;
    sln_d      = 1'b1;
    aln_d      = aln_q;
    d_d        = d_q;
    clr_ack_d  = 1'b0;
    err_d      = 1'b0;
    load_cnt_d = load_cnt_q;
    clr_pend_d = clr_pend_q;

    unique case (state_q)
      ST_INIT: begin
        aln_d = 1'b0;
        if (clr_req) clr_pend_d = 1'b1;
        if (init_cnt_q == IW'(INIT_CYCLES - 1)) begin
          aln_d   = 1'b1;
          ready_d = 1'b1;
          state_d = ST_COLLECT;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end

      ST_COLLECT: begin
        ready_d = 1'b1;
        if (clr_now) begin
          state_d    = ST_CLEAR;
          ready_d    = 1'b0;
          en_d       = 1'b1;
          sln_d      = 1'b0;
          clr_ack_d  = 1'b1;
          clr_pend_d = 1'b0;
        end else if (frame_done) begin
          // LOAD is entered for bad-parity frames too, so the post-frame
          // cycle is always a no-accept cycle; only the strobe is withheld.
          state_d = ST_LOAD;
          ready_d = 1'b0;
          if (parity_ok) begin
            en_d       = 1'b1;
            d_d        = word;
            load_cnt_d = load_cnt_q + 8'd1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        if (clr_req) clr_pend_d = 1'b1;
        ready_d = 1'b1;
        state_d = ST_COLLECT;
      end

      ST_CLEAR: begin
        ready_d = 1'b1;
        state_d = ST_COLLECT;
      end

      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
      en_q       <= 1'b0;
      sln_q      <= 1'b1;
      aln_q      <= 1'b0;
      d_q        <= '0;
      clr_ack_q  <= 1'b0;
      err_q      <= 1'b0;
      load_cnt_q <= '0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ready_q    <= ready_d;
      en_q       <= en_d;
      sln_q      <= sln_d;
      aln_q      <= aln_d;
      d_q        <= d_d;
      clr_ack_q  <= clr_ack_d;
      err_q      <= err_d;
      load_cnt_q <= load_cnt_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  assign D        = d_q;
  assign EN       = en_q;
  assign SLn      = sln_q;
  assign SD       = 1'b0;
  assign ALn      = aln_q;
  assign ADn      = ~INIT_VAL;
  assign LAT      = 1'b0;
  assign clr_ack  = clr_ack_q;
  assign err      = err_q;
  assign load_cnt = load_cnt_q;

endmodule

// File: tb/tb_sle_stream_loader.sv
// tb/tb_sle_stream_loader.sv - directed self-checking bench for sle_stream_loader
module tb_sle_stream_loader;

  logic       clk;
  logic       rst_n;
  logic       s_data;
  logic       s_valid;
  logic       s_ready;
  logic       clr_req;
  logic       clr_ack;
  logic [7:0] d;
  logic       en;
  logic       sln;
  logic       sd;
  logic       aln;
  logic       adn;
  logic       lat;
  logic       err;
  logic [7:0] load_cnt;

  int         tests;
  int         fails;
  logic [7:0] exp_cnt;

  sle_stream_loader #(.WIDTH(8), .INIT_CYCLES(2), .INIT_VAL(1'b1)) dut (
    .CLK      (clk),
    .RSTn     (rst_n),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .clr_req  (clr_req),
    .clr_ack  (clr_ack),
    .D        (d),
    .EN       (en),
    .SLn      (sln),
    .SD       (sd),
    .ALn      (aln),
    .ADn      (adn),
    .LAT      (lat),
    .err      (err),
    .load_cnt (load_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Presents one bit, waits (bounded) for s_ready, returns at the negedge
  // after the accepting edge with s_valid dropped.
  task automatic send_bit(input logic b, input int gap);
    int waited;
    s_valid = 1'b0;
    repeat (gap) tick();
    s_data  = b;
    s_valid = 1'b1;
    #1;
    waited = 0;
    while (!s_ready && waited < 40) begin
      tick();
      #1;
      waited++;
    end
    if (!s_ready) begin
      tests++; fails++;
      $display("FAIL send_bit_timeout: s_ready=%b want 1", s_ready);
    end
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input bit gaps);
    for (int b = 7; b >= 0; b--) send_bit(w[b], (gaps && b == 4) ? 2 : 0);
`ifdef SLE_LDR_PARITY_EN
    send_bit(^w, 0);
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_data = 1'b0; clr_req = 1'b0;
    exp_cnt = 8'd0;
    repeat (3) tick();
    #1;
    tests++; if (aln !== 1'b0) begin fails++; $display("FAIL reset_aln: got %b want 0", aln); end
    tests++; if (adn !== 1'b0) begin fails++; $display("FAIL reset_adn: got %b want 0", adn); end
    tests++; if ({en, sln, sd, lat} !== 4'b0100) begin fails++; $display("FAIL reset_ctl: got en/sln/sd/lat=%b want 0100", {en, sln, sd, lat}); end
    tests++; if (d !== 8'h00 || load_cnt !== 8'h00) begin fails++; $display("FAIL reset_d_cnt: got d=%h cnt=%0d want 00/0", d, load_cnt); end
    tests++; if ({s_ready, clr_ack, err} !== 3'b000) begin fails++; $display("FAIL reset_flags: got rdy/ack/err=%b want 000", {s_ready, clr_ack, err}); end
    rst_n = 1'b1;
    #1;
    tests++; if (aln !== 1'b0 || s_ready !== 1'b0) begin fails++; $display("FAIL init_c0: got aln=%b rdy=%b want 0/0", aln, s_ready); end
    tick(); #1;
    tests++; if (aln !== 1'b0 || s_ready !== 1'b0 || adn !== 1'b0) begin fails++; $display("FAIL init_c1: got aln=%b rdy=%b adn=%b want 0/0/0", aln, s_ready, adn); end
    tick(); #1;
    tests++; if (aln !== 1'b1 || s_ready !== 1'b1) begin fails++; $display("FAIL init_c2: got aln=%b rdy=%b want 1/1", aln, s_ready); end
  endtask

  task automatic test_word();
    send_word(8'hB2, 1'b0);
    exp_cnt = exp_cnt + 8'd1;
    #1;
    tests++; if (d !== 8'hB2) begin fails++; $display("FAIL word_d: got %h want b2", d); end
    tests++; if (en !== 1'b1 || sln !== 1'b1 || s_ready !== 1'b0) begin fails++; $display("FAIL word_strobe: got en=%b sln=%b rdy=%b want 1/1/0", en, sln, s_ready); end
    tests++; if (load_cnt !== exp_cnt) begin fails++; $display("FAIL word_cnt: got %0d want %0d", load_cnt, exp_cnt); end
    tick(); #1;
    tests++; if (en !== 1'b0 || d !== 8'hB2 || s_ready !== 1'b1) begin fails++; $display("FAIL word_after: got en=%b d=%h rdy=%b want 0/b2/1", en, d, s_ready); end
  endtask

  task automatic test_clear_mid_frame();
    send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
    clr_req = 1'b1;
    #1;
    tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL clr_ready_drop: got %b want 0", s_ready); end
    tick(); #1;
    tests++; if ({en, sln, sd, clr_ack} !== 4'b1001) begin fails++; $display("FAIL clr_strobe: got en/sln/sd/ack=%b want 1001", {en, sln, sd, clr_ack}); end
    tests++; if (d !== 8'hB2 || load_cnt !== exp_cnt) begin fails++; $display("FAIL clr_hold: got d=%h cnt=%0d want b2/%0d", d, load_cnt, exp_cnt); end
    clr_req = 1'b0;
    tick(); #1;
    tests++; if (en !== 1'b0 || clr_ack !== 1'b0 || sln !== 1'b1) begin fails++; $display("FAIL clr_end: got en=%b ack=%b sln=%b want 0/0/1", en, clr_ack, sln); end
    for (int i = 0; i < 7; i++) send_bit(1'b1, 0);
    #1;
    tests++; if (en !== 1'b0 || load_cnt !== exp_cnt) begin fails++; $display("FAIL clr_leftover: got en=%b cnt=%0d want 0/%0d", en, load_cnt, exp_cnt); end
    send_bit(1'b1, 0);
`ifdef SLE_LDR_PARITY_EN
    send_bit(1'b0, 0);
`endif
    exp_cnt = exp_cnt + 8'd1;
    #1;
    tests++; if (d !== 8'hFF || en !== 1'b1 || load_cnt !== exp_cnt) begin fails++; $display("FAIL clr_next_word: got d=%h en=%b cnt=%0d want ff/1/%0d", d, en, load_cnt, exp_cnt); end
    tick();
  endtask

  task automatic test_clr_priority();
    s_data = 1'b1; s_valid = 1'b1; clr_req = 1'b1;
    #1;
    tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL prio_ready: got %b want 0", s_ready); end
    tick(); #1;
    tests++; if ({en, sln, clr_ack} !== 3'b101) begin fails++; $display("FAIL prio_clear: got en/sln/ack=%b want 101", {en, sln, clr_ack}); end
    clr_req = 1'b0; s_valid = 1'b0;
    tick();
    send_word(8'h5A, 1'b0);
    exp_cnt = exp_cnt + 8'd1;
    #1;
    tests++; if (d !== 8'h5A || load_cnt !== exp_cnt) begin fails++; $display("FAIL prio_word: got d=%h cnt=%0d want 5a/%0d", d, load_cnt, exp_cnt); end
    tick();
  endtask

  task automatic test_clr_held();
    clr_req = 1'b1;
    tick(); #1;
    tests++; if (clr_ack !== 1'b1) begin fails++; $display("FAIL held_ack0: got %b want 1", clr_ack); end
    tick(); #1;
    tests++; if (clr_ack !== 1'b0 || s_ready !== 1'b0 || en !== 1'b0) begin fails++; $display("FAIL held_gap: got ack=%b rdy=%b en=%b want 0/0/0", clr_ack, s_ready, en); end
    tick(); #1;
    tests++; if (clr_ack !== 1'b1) begin fails++; $display("FAIL held_ack1: got %b want 1", clr_ack); end
    clr_req = 1'b0;
    tick(); #1;
    tests++; if (clr_ack !== 1'b0 || s_ready !== 1'b1) begin fails++; $display("FAIL held_end: got ack=%b rdy=%b want 0/1", clr_ack, s_ready); end
  endtask

  task automatic test_clr_during_load();
    send_word(8'h3C, 1'b0);
    exp_cnt = exp_cnt + 8'd1;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    #1;
    tests++; if (clr_ack !== 1'b0 || s_ready !== 1'b0) begin fails++; $display("FAIL load_clr_pend: got ack=%b rdy=%b want 0/0", clr_ack, s_ready); end
    tick(); #1;
    tests++; if (clr_ack !== 1'b1 || sln !== 1'b0 || d !== 8'h3C) begin fails++; $display("FAIL load_clr_serve: got ack=%b sln=%b d=%h want 1/0/3c", clr_ack, sln, d); end
    tick(); #1;
    tests++; if (clr_ack !== 1'b0 || s_ready !== 1'b1) begin fails++; $display("FAIL load_clr_end: got ack=%b rdy=%b want 0/1", clr_ack, s_ready); end
  endtask

  task automatic test_wrap();
    logic [7:0] w;
    int         n;
    n = 256 - int'(exp_cnt);
    for (int i = 0; i < n; i++) begin
      w = 8'(i * 37 + 11);
      send_word(w, (i % 3) == 0);
      exp_cnt = exp_cnt + 8'd1;
      #1;
      tests++; if (d !== w || en !== 1'b1) begin fails++; $display("FAIL wrap_word%0d: got d=%h en=%b want %h/1", i, d, en, w); end
      if (i == n - 2) begin
        tests++; if (load_cnt !== 8'd255) begin fails++; $display("FAIL wrap_255: got %0d want 255", load_cnt); end
      end
    end
    tests++; if (load_cnt !== 8'd0) begin fails++; $display("FAIL wrap_zero: got %0d want 0", load_cnt); end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
    rst_n = 1'b0;
    #1;
    tests++; if (aln !== 1'b0 || d !== 8'h00 || load_cnt !== 8'd0 || s_ready !== 1'b0) begin fails++; $display("FAIL rst_mid: got aln=%b d=%h cnt=%0d rdy=%b want 0/00/0/0", aln, d, load_cnt, s_ready); end
    tick();
    rst_n = 1'b1;
    exp_cnt = 8'd0;
    tick(); tick(); #1;
    tests++; if (aln !== 1'b1 || s_ready !== 1'b1) begin fails++; $display("FAIL rst_reinit: got aln=%b rdy=%b want 1/1", aln, s_ready); end
    send_word(8'hC3, 1'b0);
    exp_cnt = exp_cnt + 8'd1;
    #1;
    tests++; if (d !== 8'hC3 || load_cnt !== exp_cnt) begin fails++; $display("FAIL rst_word: got d=%h cnt=%0d want c3/%0d", d, load_cnt, exp_cnt); end
    tick();
  endtask

`ifdef SLE_LDR_PARITY_EN
  task automatic test_parity();
    logic [7:0] w;
    w = 8'hB2;
    for (int b = 7; b >= 0; b--) send_bit(w[b], 0);
    send_bit(1'b1, 0);
    #1;
    tests++; if (err !== 1'b1 || en !== 1'b0) begin fails++; $display("FAIL par_bad: got err=%b en=%b want 1/0", err, en); end
    tests++; if (load_cnt !== exp_cnt || d !== 8'hC3) begin fails++; $display("FAIL par_bad_hold: got cnt=%0d d=%h want %0d/c3", load_cnt, d, exp_cnt); end
    tick(); #1;
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL par_err_pulse: got %b want 0", err); end
    for (int b = 7; b >= 0; b--) send_bit(w[b], 0);
    send_bit(1'b0, 0);
    exp_cnt = exp_cnt + 8'd1;
    #1;
    tests++; if (en !== 1'b1 || d !== 8'hB2 || err !== 1'b0 || load_cnt !== exp_cnt) begin fails++; $display("FAIL par_good: got en=%b d=%h err=%b cnt=%0d want 1/b2/0/%0d", en, d, err, load_cnt, exp_cnt); end
    tick();
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0; s_valid = 1'b0; s_data = 1'b0; clr_req = 1'b0;
    test_reset();
    test_word();
    test_clear_mid_frame();
    test_clr_priority();
    test_clr_held();
    test_clr_during_load();
    test_wrap();
    test_reset_mid_frame();
`ifdef SLE_LDR_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
